// File: rtl/bus_hs_sync_if.sv
// -----------------------------------------------------------------------------
// bus_hs_sync_if
// Bundles the handshake and data signals of bus_hs_sync so that the block and
// its users connect through one port. The clocks and resets are not part of
// the bundle; they stay scalar ports on the block.
//
// Signals:
//   src_vld   source word valid                  (clk_src domain)
//   src_rdy   synchroniser can accept a word     (clk_src domain)
//   src_data  source word, DWID bits             (clk_src domain)
//   src_busy  a transfer is in flight            (clk_src domain)
//   dst_vld   destination word valid             (clk_dst domain)
//   dst_data  destination word, DWID bits        (clk_dst domain)
//   dst_rdy   destination accepts dst_data       (clk_dst domain, optional)
//
// Modports:
//   master  the user side: drives src_vld/src_data (and dst_rdy)
//   slave   the synchroniser side
//
// Optional feature macro: BUS_HS_SYNC_DST_RDY_EN adds dst_rdy.
// -----------------------------------------------------------------------------
interface bus_hs_sync_if #(
  parameter int unsigned DWID = 32
);

  logic            src_vld;
  logic            src_rdy;
  logic [DWID-1:0] src_data;
  logic            src_busy;
  logic            dst_vld;
  logic [DWID-1:0] dst_data;

`ifdef BUS_HS_SYNC_DST_RDY_EN
  logic            dst_rdy;

  modport master (
    output src_vld,
    output src_data,
    output dst_rdy,
    input  src_rdy,
    input  src_busy,
    input  dst_vld,
    input  dst_data
  );

  modport slave (
    input  src_vld,
    input  src_data,
    input  dst_rdy,
    output src_rdy,
    output src_busy,
    output dst_vld,
    output dst_data
  );
`else
  modport master (
    output src_vld,
    output src_data,
    input  src_rdy,
    input  src_busy,
    input  dst_vld,
    input  dst_data
  );

  modport slave (
    input  src_vld,
    input  src_data,
    output src_rdy,
    output src_busy,
    output dst_vld,
    output dst_data
  );
`endif

endinterface

// File: rtl/bus_hs_sync.sv
// -----------------------------------------------------------------------------
// bus_hs_sync
// Moves a DWID-bit word from clk_src to clk_dst with a 2-phase (toggle)
// req/ack handshake. The word sits in a source-side hold register that is
// frozen while the request toggle crosses, so the destination always captures
// a coherent word with no bit skew.
//
// Parameters:
//   DWID         data width (>= 1)
//   SYNC_STAGES  flops per synchroniser chain; values below 2 are built as 2
//   RST_VAL      reset value of dst_data
//
// Ports:
//   clk_src, rst_n_src   source clock and async active-low reset
//   clk_dst, rst_n_dst   destination clock and async active-low reset
//   bus                  bus_hs_sync_if.slave carrying src_vld, src_rdy,
//                        src_data, src_busy, dst_vld, dst_data (+ dst_rdy)
//
// Optional feature macro: BUS_HS_SYNC_DST_RDY_EN
//   Defined:   dst_vld is held until dst_vld & dst_rdy, and the ack toggle only
//              moves on that accept, so the source stays busy until the word
//              has been consumed.
//   Undefined: dst_vld is a one-cycle pulse and ack returns straight away.
//
// Both resets are meant to be asserted together; asserting only rst_n_src
// during a transfer may or may not let the in-flight word reach dst.
// -----------------------------------------------------------------------------
module bus_hs_sync #(
  parameter int unsigned     DWID        = 32,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [DWID-1:0] RST_VAL     = {DWID{1'b0}}
) (
  input  logic         clk_src,
  input  logic         rst_n_src,
  input  logic         clk_dst,
  input  logic         rst_n_dst,
  bus_hs_sync_if.slave bus
);

  // Effective chain depth: fewer than two flops is not a synchroniser.
  localparam int unsigned SS = (SYNC_STAGES < 32'd2) ? 32'd2 : SYNC_STAGES;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } src_state_e;

  // ---------------------------------------------------------------------------
  // Source domain signals
  // ---------------------------------------------------------------------------
  src_state_e      state_r;
  src_state_e      state_nxt_s;
  logic            req_tgl_r;
  logic            req_tgl_nxt_s;
  logic            hold_load_s;
  logic [DWID-1:0] data_hold_r;
  logic            src_rdy_r;
  logic            src_busy_r;
  logic            ack_sync_last_s;

  (* ASYNC_REG = "TRUE", keep = "true" *)
  logic [SS-1:0]   ack_sync_r;

  // ---------------------------------------------------------------------------
  // Destination domain signals
  // ---------------------------------------------------------------------------
  (* ASYNC_REG = "TRUE", keep = "true" *)
  logic [SS-1:0]   req_sync_r;
  logic            req_edge_r;
  logic            req_chg_s;
  logic            ack_tgl_r;
  logic            ack_tgl_nxt_s;
  logic            dst_vld_r;
  logic            dst_vld_nxt_s;
  logic            dst_load_s;
  logic [DWID-1:0] dst_data_r;

  // ===========================================================================
  // Source side (clk_src)
  // ===========================================================================

  // Brings the destination ack toggle into clk_src.
  always_ff @(posedge clk_src or negedge rst_n_src) begin
    if (!rst_n_src) begin
      ack_sync_r <= {SS{1'b0}};
    end else begin
      ack_sync_r <= {ack_sync_r[SS-2:0], ack_tgl_r};
    end
  end

  assign ack_sync_last_s = ack_sync_r[SS-1];

  // Source FSM next state: accept in IDLE, wait for ack to match req in BUSY.
  always_comb begin
    state_nxt_s   = state_r;
    req_tgl_nxt_s = req_tgl_r;
    hold_load_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        // src_rdy_r is high throughout IDLE, so this is src_vld & src_rdy.
        if (bus.src_vld && src_rdy_r) begin
          state_nxt_s   = S_BUSY;
          req_tgl_nxt_s = ~req_tgl_r;
          hold_load_s   = 1'b1;
        end else begin
          state_nxt_s   = S_IDLE;
        end
      end
      S_BUSY: begin
        // Ack catching up with req means the destination has the word.
        if (ack_sync_last_s == req_tgl_r) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_BUSY;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Source FSM state, request toggle and registered ready/busy flags.
  always_ff @(posedge clk_src or negedge rst_n_src) begin
    if (!rst_n_src) begin
      state_r    <= S_IDLE;
      req_tgl_r  <= 1'b0;
      src_rdy_r  <= 1'b1;
      src_busy_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      req_tgl_r  <= req_tgl_nxt_s;
      // Taken from the next state so both flags change on the same edge as
      // the FSM; a new accept can therefore never land on the release edge.
      src_rdy_r  <= (state_nxt_s == S_IDLE);
      src_busy_r <= (state_nxt_s == S_BUSY);
    end
  end

  // Hold register: only an accept loads it, so it is frozen while req != ack.
  always_ff @(posedge clk_src or negedge rst_n_src) begin
    if (!rst_n_src) begin
      data_hold_r <= {DWID{1'b0}};
    end else if (hold_load_s) begin
      data_hold_r <= bus.src_data;
    end
  end

  assign bus.src_rdy  = src_rdy_r;
  assign bus.src_busy = src_busy_r;

  // ===========================================================================
  // Destination side (clk_dst)
  // ===========================================================================

  // Brings the source request toggle into clk_dst, plus one flop for edge detect.
  always_ff @(posedge clk_dst or negedge rst_n_dst) begin
    if (!rst_n_dst) begin
      req_sync_r <= {SS{1'b0}};
      req_edge_r <= 1'b0;
    end else begin
      req_sync_r <= {req_sync_r[SS-2:0], req_tgl_r};
      req_edge_r <= req_sync_r[SS-1];
    end
  end

  // Either polarity of toggle is a new word.
  assign req_chg_s = req_sync_r[SS-1] ^ req_edge_r;

  // Destination next state: capture on a req edge and decide when to ack.
  always_comb begin
    dst_vld_nxt_s = dst_vld_r;
    ack_tgl_nxt_s = ack_tgl_r;
    dst_load_s    = req_chg_s;
`ifdef BUS_HS_SYNC_DST_RDY_EN
    // A new req edge cannot coincide with an accept: the source only sends
    // again after the ack that the accept produces.
    if (req_chg_s) begin
      dst_vld_nxt_s = 1'b1;
    end else if (dst_vld_r && bus.dst_rdy) begin
      dst_vld_nxt_s = 1'b0;
      ack_tgl_nxt_s = ~ack_tgl_r;
    end else begin
      dst_vld_nxt_s = dst_vld_r;
    end
`else
    dst_vld_nxt_s = req_chg_s;
    if (req_chg_s) begin
      ack_tgl_nxt_s = req_sync_r[SS-1];
    end else begin
      ack_tgl_nxt_s = ack_tgl_r;
    end
`endif
  end

  // Destination valid, ack toggle and captured word.
  always_ff @(posedge clk_dst or negedge rst_n_dst) begin
    if (!rst_n_dst) begin
      dst_vld_r  <= 1'b0;
      ack_tgl_r  <= 1'b0;
      dst_data_r <= RST_VAL;
    end else begin
      dst_vld_r  <= dst_vld_nxt_s;
      ack_tgl_r  <= ack_tgl_nxt_s;
      // data_hold_r is stable here: req has toggled and ack has not yet.
      if (dst_load_s) begin
        dst_data_r <= data_hold_r;
      end
    end
  end

  assign bus.dst_vld  = dst_vld_r;
  assign bus.dst_data = dst_data_r;

endmodule

// File: tb/tb_bus_hs_sync.sv
// -----------------------------------------------------------------------------
// tb_bus_hs_sync
// Directed bench for bus_hs_sync. One time unit stands for 0.1 ns:
// 100 MHz = 100 units per period, ~37 MHz = 270 units per period.
// u_dut  : DWID=32, SYNC_STAGES=2, RST_VAL=0xDEAD_BEEF, separate clocks.
// u_dut3 : DWID=8,  SYNC_STAGES=3, both ports on one gated clock clk_eq.
// -----------------------------------------------------------------------------
module tb_bus_hs_sync;

  localparam logic [31:0] RST_WORD  = 32'hDEAD_BEEF;
  localparam int          FAST_HALF = 50;
  localparam int          SLOW_HALF = 135;
`ifdef BUS_HS_SYNC_DST_RDY_EN
  localparam int          ACK_EXTRA = 1;
`else
  localparam int          ACK_EXTRA = 0;
`endif

  logic clk_src;
  logic clk_dst;
  logic rst_n_src;
  logic rst_n_dst;
  logic clk_eq;
  logic rst_n3;

  int   src_half = FAST_HALF;
  int   dst_half = SLOW_HALF;
  bit   eq_run   = 1'b0;

  int   checks = 0;
  int   errors = 0;

  logic [31:0] got_q[$];
  int          wide_cnt = 0;
  logic        mon_prev = 1'b0;

  bus_hs_sync_if #(.DWID(32)) bus ();
  bus_hs_sync_if #(.DWID(8))  bus3 ();

  bus_hs_sync #(.DWID(32), .SYNC_STAGES(2), .RST_VAL(RST_WORD)) u_dut (
    .clk_src   (clk_src),
    .rst_n_src (rst_n_src),
    .clk_dst   (clk_dst),
    .rst_n_dst (rst_n_dst),
    .bus       (bus)
  );

  bus_hs_sync #(.DWID(8), .SYNC_STAGES(3), .RST_VAL(8'h00)) u_dut3 (
    .clk_src   (clk_eq),
    .rst_n_src (rst_n3),
    .clk_dst   (clk_eq),
    .rst_n_dst (rst_n3),
    .bus       (bus3)
  );

  initial begin
    clk_src = 1'b0;
    forever begin
      #(src_half);
      clk_src = ~clk_src;
    end
  end

  initial begin
    clk_dst = 1'b0;
    forever begin
      #(dst_half);
      clk_dst = ~clk_dst;
    end
  end

  initial begin
    clk_eq = 1'b0;
    forever begin
      #50;
      if (eq_run) clk_eq = ~clk_eq;
    end
  end

  // Destination monitor: records each new dst_vld word, counts wide pulses.
  initial begin
    forever begin
      @(posedge clk_dst);
      #1;
      if (bus.dst_vld === 1'b1 && mon_prev !== 1'b1) got_q.push_back(bus.dst_data);
      if (bus.dst_vld === 1'b1 && mon_prev === 1'b1) wide_cnt++;
      mon_prev = bus.dst_vld;
    end
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present w and hold src_vld until an edge accepts it; returns just after it.
  task automatic send_word(input logic [31:0] w, output bit ok, output time t_acc);
    int n;
    n = 0;
    bus.src_data = w;
    bus.src_vld  = 1'b1;
    while (bus.src_rdy !== 1'b1 && n < 2000) begin
      @(posedge clk_src);
      #1;
      n++;
    end
    ok = (bus.src_rdy === 1'b1);
    @(posedge clk_src);
    t_acc = $time;
    #1;
  endtask

  task automatic wait_rdy(output bit ok);
    int n;
    n = 0;
    while (bus.src_rdy !== 1'b1 && n < 2000) begin
      @(posedge clk_src);
      #1;
      n++;
    end
    ok = (bus.src_rdy === 1'b1);
  endtask

  task automatic test_reset();
    #500;
    @(posedge clk_src);
    #1;
    rst_n_src = 1'b1;
    rst_n_dst = 1'b1;
    repeat (3) @(posedge clk_src);
    #1;
    checks++;
    if (bus.src_rdy !== 1'b1) begin errors++; $display("FAIL reset_src_rdy: got %b expected 1", bus.src_rdy); end
    checks++;
    if (bus.src_busy !== 1'b0) begin errors++; $display("FAIL reset_src_busy: got %b expected 0", bus.src_busy); end
    checks++;
    if (bus.dst_vld !== 1'b0) begin errors++; $display("FAIL reset_dst_vld: got %b expected 0", bus.dst_vld); end
    checks++;
    if (bus.dst_data !== RST_WORD) begin errors++; $display("FAIL reset_dst_data: got %h expected %h", bus.dst_data, RST_WORD); end
  endtask

  task automatic test_single();
    bit  ok;
    time t_acc;
    time t_rdy;
    time limit;
    src_half = FAST_HALF;
    dst_half = SLOW_HALF;
    repeat (4) @(posedge clk_src);
    #1;
    got_q.delete();
    wide_cnt = 0;
    send_word(32'hA5A5_0F0F, ok, t_acc);
    bus.src_vld = 1'b0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL single_accept: got %b expected 1", ok); end
    checks++;
    if (bus.src_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.src_busy); end
    wait_rdy(ok);
    t_rdy = $time - 1;
    limit = 3 * 270 + 4 * 100 + ACK_EXTRA * 270;
    checks++;
    if (ok !== 1'b1 || (t_rdy - t_acc) > limit) begin
      errors++;
      $display("FAIL single_rdy_latency: got %0d units expected <= %0d", t_rdy - t_acc, limit);
    end
    repeat (4) @(posedge clk_dst);
    #1;
    checks++;
    if (got_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    checks++;
    if (got_q.size() > 0 && got_q[0] !== 32'hA5A5_0F0F) begin
      errors++;
      $display("FAIL single_data: got %h expected a5a50f0f", got_q[0]);
    end
    checks++;
    if (wide_cnt !== 0) begin errors++; $display("FAIL single_pulse_width: got %0d wide expected 0", wide_cnt); end
  endtask

  task automatic test_stream(input int sh, input int dh, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] w;
    bit          ok;
    bit          all_ok;
    time         t;
    src_half = sh;
    dst_half = dh;
    repeat (4) @(posedge clk_src);
    #1;
    got_q.delete();
    wide_cnt = 0;
    all_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      w = $urandom;
      send_word(w, ok, t);
      if (ok !== 1'b1) begin
        all_ok = 1'b0;
        break;
      end
      exp_q.push_back(w);
    end
    bus.src_vld = 1'b0;
    wait_rdy(ok);
    repeat (4) @(posedge clk_dst);
    #1;
    checks++;
    if (all_ok !== 1'b1 || ok !== 1'b1) begin errors++; $display("FAIL %s_accept: got timeout expected all accepted", tag); end
    checks++;
    if (got_q.size() !== exp_q.size() || exp_q.size() !== 1000) begin
      errors++;
      $display("FAIL %s_count: got %0d expected %0d", tag, got_q.size(), 1000);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_word[%0d]: got %h expected %h", tag, i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (wide_cnt !== 0) begin errors++; $display("FAIL %s_pulse_width: got %0d wide expected 0", tag, wide_cnt); end
  endtask

  task automatic test_busy_change();
    bit  ok;
    time t;
    src_half = FAST_HALF;
    dst_half = SLOW_HALF;
    repeat (4) @(posedge clk_src);
    #1;
    got_q.delete();
    send_word(32'h0000_0001, ok, t);
    bus.src_data = 32'hFFFF_FFFF;
    wait_rdy(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL busy_first_rdy: got timeout expected src_rdy"); end
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== 32'h0000_0001) begin
      errors++;
      $display("FAIL busy_first_word: got %0d words expected exactly 00000001", got_q.size());
    end
    @(posedge clk_src);
    #1;
    bus.src_vld = 1'b0;
    checks++;
    if (bus.src_busy !== 1'b1) begin errors++; $display("FAIL busy_second_accept: got %b expected 1", bus.src_busy); end
    wait_rdy(ok);
    repeat (4) @(posedge clk_dst);
    #1;
    checks++;
    if (got_q.size() !== 2 || got_q[1] !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL busy_second_word: got %0d words expected 2 ending ffffffff", got_q.size());
    end
  endtask

  task automatic test_sync3();
    logic [7:0] vec [2];
    logic [7:0] got;
    int         k;
    int         n_vld;
    vec[0] = 8'h5A;
    vec[1] = 8'hC3;
    eq_run = 1'b1;
    repeat (3) @(posedge clk_eq);
    #1;
    rst_n3 = 1'b1;
    repeat (2) @(posedge clk_eq);
    #1;
    checks++;
    if (bus3.src_rdy !== 1'b1 || bus3.dst_vld !== 1'b0) begin
      errors++;
      $display("FAIL sync3_reset: got rdy=%b vld=%b expected rdy=1 vld=0", bus3.src_rdy, bus3.dst_vld);
    end
    for (int v = 0; v < 2; v++) begin
      bus3.src_data = vec[v];
      bus3.src_vld  = 1'b1;
      @(posedge clk_eq);
      #1;
      bus3.src_vld = 1'b0;
      k     = 0;
      n_vld = -1;
      got   = 8'h00;
      while (k < 40 && bus3.src_rdy !== 1'b1) begin
        @(posedge clk_eq);
        #1;
        k++;
        if (bus3.dst_vld === 1'b1 && n_vld < 0) begin
          n_vld = k;
          got   = bus3.dst_data;
        end
      end
      checks++;
      if (n_vld !== 4) begin errors++; $display("FAIL sync3_vld_latency[%0d]: got %0d edges expected 4", v, n_vld); end
      checks++;
      if (got !== vec[v]) begin errors++; $display("FAIL sync3_data[%0d]: got %h expected %h", v, got, vec[v]); end
      checks++;
      if (bus3.src_rdy !== 1'b1 || k !== 8 + ACK_EXTRA) begin
        errors++;
        $display("FAIL sync3_rdy_latency[%0d]: got %0d edges expected %0d", v, k, 8 + ACK_EXTRA);
      end
    end
    eq_run = 1'b0;
  endtask

  task automatic test_both_reset();
    bit  ok;
    time t;
    src_half = FAST_HALF;
    dst_half = SLOW_HALF;
    repeat (4) @(posedge clk_src);
    #1;
    got_q.delete();
    send_word(32'h1234_5678, ok, t);
    bus.src_vld = 1'b0;
    @(posedge clk_src);
    #1;
    rst_n_src = 1'b0;
    rst_n_dst = 1'b0;
    #20;
    checks++;
    if (bus.src_rdy !== 1'b1 || bus.src_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_src: got rdy=%b busy=%b expected rdy=1 busy=0", bus.src_rdy, bus.src_busy);
    end
    checks++;
    if (bus.dst_vld !== 1'b0 || bus.dst_data !== RST_WORD) begin
      errors++;
      $display("FAIL rst_mid_dst: got vld=%b data=%h expected vld=0 data=%h", bus.dst_vld, bus.dst_data, RST_WORD);
    end
    @(posedge clk_src);
    #1;
    rst_n_src = 1'b1;
    rst_n_dst = 1'b1;
    repeat (20) @(posedge clk_dst);
    #1;
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL rst_no_pulse: got %0d words expected 0", got_q.size()); end
    checks++;
    if (bus.dst_data !== RST_WORD) begin errors++; $display("FAIL rst_dst_data: got %h expected %h", bus.dst_data, RST_WORD); end
    checks++;
    if (bus.src_rdy !== 1'b1) begin errors++; $display("FAIL rst_src_rdy: got %b expected 1", bus.src_rdy); end
    send_word(32'h0BAD_F00D, ok, t);
    bus.src_vld = 1'b0;
    wait_rdy(ok);
    repeat (4) @(posedge clk_dst);
    #1;
    checks++;
    if (ok !== 1'b1 || got_q.size() !== 1 || got_q[0] !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL rst_next_transfer: got %0d words expected one 0badf00d", got_q.size());
    end
  endtask

`ifdef BUS_HS_SYNC_DST_RDY_EN
  task automatic test_dst_rdy();
    bit  ok;
    bit  stable;
    bit  held_busy;
    time t;
    int  n;
    src_half = FAST_HALF;
    dst_half = SLOW_HALF;
    repeat (4) @(posedge clk_src);
    #1;
    bus.dst_rdy = 1'b0;
    send_word(32'h7777_0001, ok, t);
    bus.src_vld = 1'b0;
    n = 0;
    while (bus.dst_vld !== 1'b1 && n < 50) begin
      @(posedge clk_dst);
      #1;
      n++;
    end
    checks++;
    if (bus.dst_vld !== 1'b1) begin errors++; $display("FAIL rdy_vld_rise: got %b expected 1", bus.dst_vld); end
    stable    = 1'b1;
    held_busy = 1'b1;
    repeat (20) begin
      @(posedge clk_dst);
      #1;
      if (bus.dst_vld !== 1'b1 || bus.dst_data !== 32'h7777_0001) stable = 1'b0;
      if (bus.src_rdy !== 1'b0) held_busy = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL rdy_hold_data: got unstable expected vld=1 data=77770001"); end
    checks++;
    if (held_busy !== 1'b1) begin errors++; $display("FAIL rdy_hold_busy: got src_rdy high expected 0"); end
    bus.dst_rdy = 1'b1;
    @(posedge clk_dst);
    #1;
    bus.dst_rdy = 1'b0;
    checks++;
    if (bus.dst_vld !== 1'b0) begin errors++; $display("FAIL rdy_vld_fall: got %b expected 0", bus.dst_vld); end
    wait_rdy(ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL rdy_src_release: got timeout expected src_rdy"); end
    bus.dst_rdy = 1'b1;
  endtask
`endif

  initial begin
    bus.src_vld   = 1'b0;
    bus.src_data  = 32'h0000_0000;
    bus3.src_vld  = 1'b0;
    bus3.src_data = 8'h00;
`ifdef BUS_HS_SYNC_DST_RDY_EN
    bus.dst_rdy   = 1'b1;
    bus3.dst_rdy  = 1'b1;
`endif
    rst_n_src = 1'b0;
    rst_n_dst = 1'b0;
    rst_n3    = 1'b0;

    test_reset();
    test_single();
    test_stream(FAST_HALF, SLOW_HALF, "fast_to_slow");
    test_stream(SLOW_HALF, FAST_HALF, "slow_to_fast");
    test_busy_change();
    test_sync3();
    test_both_reset();
`ifdef BUS_HS_SYNC_DST_RDY_EN
    test_dst_rdy();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
